// File: rtl/nand_cpu_pkg.sv
// rtl/nand_cpu_pkg.sv - shared types, widths and helpers for the NAND CPU fetch path
//
// Purpose: common definitions imported by fetch_controller and fetch_buffer.
//   PC_SIZE / INSTR_SIZE : default fetch address and instruction widths
//   OFFSET_W             : width of a branch redirect offset
//   fetch_state_t        : fetch sequencer states
//   sext_offset()        : sign-extends a redirect offset to 32 bits
package nand_cpu_pkg;

    localparam int PC_SIZE    = 16;
    localparam int INSTR_SIZE = 16;
    localparam int OFFSET_W   = 16;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HALTING,
        HALTED
    } fetch_state_t;

    // The top bit of the offset carries weight -2^(OFFSET_W-1); the caller
    // truncates the sum to its PC width, which yields modular wrap.
    function automatic logic [31:0] sext_offset(input logic [OFFSET_W-1:0] off);
        return {{(32 - OFFSET_W){off[OFFSET_W-1]}}, off};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - two-entry FIFO of fetched {pc, instr} pairs
//
// Purpose: holds returned instructions between instruction memory and the decoder.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push            write {push_pc, push_instr}; ignored when full unless popping
//   pop             remove the head entry; ignored when empty
//   flush           empty the buffer; wins over push
//   count           number of valid entries (0..2)
//   head_valid      at least one entry present
//   head_pc         pc of the head entry
//   head_instr      instruction word of the head entry
module fetch_buffer
    import nand_cpu_pkg::*;
#(
    parameter int PC_W    = PC_SIZE,
    parameter int INSTR_W = INSTR_SIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [PC_W-1:0]    push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    input  logic               flush,
    output logic [1:0]         count,
    output logic               head_valid,
    output logic [PC_W-1:0]    head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    logic [PC_W-1:0]    pc_q    [2];
    logic [PC_W-1:0]    pc_d    [2];
    logic [INSTR_W-1:0] instr_q [2];
    logic [INSTR_W-1:0] instr_d [2];
    logic [1:0]         count_q;
    logic [1:0]         count_d;

    logic pop_en;
    logic push_en;
    logic wr_idx;

    assign pop_en  = pop && (count_q != 2'd0);
    // Full-and-popping frees the tail slot in the same cycle.
    assign push_en = push && ((count_q != 2'd2) || pop_en);
    // Write slot after the optional shift: it is the count left once the pop is applied.
    assign wr_idx  = pop_en ? (count_q == 2'd2) : (count_q == 2'd1);

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop_en) begin
                pc_d[0]    = pc_q[1];
                instr_d[0] = instr_q[1];
            end
            if (push_en) begin
                pc_d[wr_idx]    = push_pc;
                instr_d[wr_idx] = push_instr;
            end
            count_d = count_q + {1'b0, push_en} - {1'b0, pop_en};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= 2'd0;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
        end else begin
            count_q <= count_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head_pc    = pc_q[0];
    assign head_instr = instr_q[0];

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer with redirect, halt and 2-entry buffer
//
// Purpose: owns the fetch PC, requests instruction words over a req/ack handshake,
// buffers them for the decoder, and applies branch redirects and halt.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   redirect_valid    branch taken; acted on only when the head is consumed
//   redirect_offset   signed offset from the consumed instruction's pc
//   halt              stop fetching; acted on only when the head is consumed
//   imem_req          memory request
//   imem_addr         address of the outstanding request, stable until ack
//   imem_ack          memory accepted the request; imem_data valid this cycle
//   imem_data         returned instruction word
//   instr_valid       buffer head valid
//   instr_data        head instruction word
//   instr_pc          head instruction address
//   instr_ready       decoder consumes the head
//   halted            fetch has stopped; only rst leaves this
module fetch_controller
    import nand_cpu_pkg::*;
#(
    parameter int PC_W      = PC_SIZE,
    parameter int INSTR_W   = INSTR_SIZE,
    parameter int BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [OFFSET_W-1:0] redirect_offset,
    input  logic                halt,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr_data,
    output logic [PC_W-1:0]     instr_pc,
    input  logic                instr_ready,
    output logic                halted
);

    // Buffer occupancy is held in 2 bits; only a depth of 2 is built.
    localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] req_addr_q, req_addr_d;
    logic            pending_q, pending_d;

    logic               buf_push;
    logic               buf_pop;
    logic               buf_flush;
    logic [1:0]         buf_count;
    logic               head_valid;
    logic [PC_W-1:0]    head_pc;
    logic [INSTR_W-1:0] head_instr;

    logic            consume;
    logic            ack;
    logic            unacked;
    logic [PC_W-1:0] target;

    fetch_buffer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (buf_push),
        .push_pc    (imem_addr),
        .push_instr (imem_data),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .count      (buf_count),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    assign consume = head_valid && instr_ready;
    assign ack     = imem_req && imem_ack;
    // A request raised this cycle and not accepted must be carried to ack,
    // so it is treated exactly like one already registered as pending.
    assign unacked = imem_req && !imem_ack;
    assign target  = head_pc + PC_W'(sext_offset(redirect_offset));

    // While a request is pending the buffer always has a slot reserved for it
    // (count + pending never exceeds the depth), so count < FULL_CNT keeps
    // the request up until it is acked.
    always_comb begin
        imem_req = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH:         imem_req = pending_q || (buf_count < FULL_CNT);
                DRAIN,
                HALTING:       imem_req = pending_q;
                default:       imem_req = 1'b0;
            endcase
        end
    end

    // The registered address is used whenever a request is outstanding; after a
    // redirect it differs from fetch_pc and is what a drain keeps presenting.
    assign imem_addr = pending_q ? req_addr_q : fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        pending_d  = pending_q;
        buf_push   = 1'b0;
        buf_pop    = 1'b0;
        buf_flush  = 1'b0;

        case (state_q)
            FETCH: begin
                if (consume && halt) begin
                    // Halt wins over a simultaneous redirect; fetch_pc stays put.
                    buf_flush  = 1'b1;
                    pending_d  = unacked;
                    req_addr_d = imem_addr;
                    state_d    = unacked ? HALTING : HALTED;
                end else if (consume && redirect_valid) begin
                    // Any word acked this cycle belongs to the old path and is dropped.
                    buf_flush  = 1'b1;
                    fetch_pc_d = target;
                    pending_d  = unacked;
                    req_addr_d = imem_addr;
                    state_d    = unacked ? DRAIN : FETCH;
                end else begin
                    buf_pop = consume;
                    if (ack) begin
                        buf_push   = 1'b1;
                        fetch_pc_d = fetch_pc_q + PC_W'(1);
                        pending_d  = 1'b0;
                    end else if (imem_req) begin
                        pending_d  = 1'b1;
                        req_addr_d = imem_addr;
                    end
                end
            end
            DRAIN: begin
                if (ack) begin
                    pending_d = 1'b0;
                    state_d   = FETCH;
                end
            end
            HALTING: begin
                if (ack) begin
                    pending_d = 1'b0;
                    state_d   = HALTED;
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= '0;
            req_addr_q <= '0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            pending_q  <= pending_d;
        end
    end

    assign instr_valid = head_valid;
    assign instr_data  = head_instr;
    assign instr_pc    = head_pc;
    assign halted      = (state_q == HALTED);

endmodule
